ldpc_iter_ctrl: RTL and testbench

Iteration controller for the layered-free flooding LDPC decoder array (CNU/VNU banks plus cyclic-shift interconnect). It accepts a decode request and registers the shift matrix. It then sequences alternating check-node and variable-node phases for a bounded number of iterations, and returns the hard decisions through a valid/ready output handshake. It sits between the frame source and the decoder array and owns every datapath enable.

---
 rtl/ldpc_iter_ctrl_pkg.sv | 22 ++
 rtl/ldpc_iter_ctrl_phase_timer.sv | 29 ++
 rtl/ldpc_iter_ctrl.sv | 152 +++++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_iter_ctrl_pkg.sv
// ldpc_pkg: default geometry and FSM state type for ldpc_iter_ctrl.
// Defining EARLY_TERM_EN adds the SYN (syndrome check) state.
package ldpc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int R_DEF      = 32;
    localparam int C_DEF      = 16;
    localparam int D_DEF      = 64;
    localparam int IT_W_DEF   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNU,
        ST_VNU,
`ifdef EARLY_TERM_EN
        ST_SYN,
`endif
        ST_DONE
    } state_t;

endpackage

// File: rtl/ldpc_iter_ctrl_phase_timer.sv
// ldpc_phase_timer: loadable down-counter that flags the last cycle of a
// CNU/VNU phase; restart reloads it on phase entry.
module ldpc_phase_timer #(
    parameter int PHASE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic done
);

    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: sequences LOAD / CNU / VNU phases of the flooding LDPC
// decoder and hands back hard decisions. Optional macro: EARLY_TERM_EN.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int data_w    = DATA_W_DEF,
    parameter int R         = R_DEF,
    parameter int C         = C_DEF,
    parameter int D         = D_DEF,
    parameter int IT_W      = IT_W_DEF,
    parameter int PHASE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [IT_W-1:0]       max_iter,
    input  logic [data_w*C*R-1:0] mtx_in,
    output logic [data_w*C*R-1:0] shift_cfg,
    output logic                  llr_load,
    output logic                  cnu_en,
    output logic                  vnu_en,
    input  logic                  syn_ok,
    input  logic [R*D-1:0]        dec_in,
    output logic [R*D-1:0]        dec_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IT_W-1:0]       iter_cnt,
    output logic                  converged
);

    state_t          state;
    state_t          next_state;
    logic [IT_W-1:0] limit;
    logic [IT_W-1:0] iter_nxt;
    logic            last_iter;
    logic            phase_done;
    logic            restart;
    logic            accept;
    logic            vnu_exit;
    logic            handshake;

    assign accept    = (state == ST_IDLE) && start;
    assign vnu_exit  = (state == ST_VNU) && phase_done;
    assign handshake = out_valid && out_ready;
    assign iter_nxt  = iter_cnt + IT_W'(1);
    assign last_iter = (iter_nxt == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)      next_state = ST_LOAD;
            ST_LOAD:                 next_state = ST_CNU;
            ST_CNU:  if (phase_done) next_state = ST_VNU;
            ST_VNU: begin
                if (phase_done) begin
                    if (last_iter) begin
                        next_state = ST_DONE;
                    end else begin
`ifdef EARLY_TERM_EN
                        next_state = ST_SYN;
`else
                        next_state = ST_CNU;
`endif
                    end
                end
            end
`ifdef EARLY_TERM_EN
            ST_SYN:                  next_state = syn_ok ? ST_DONE : ST_CNU;
`endif
            ST_DONE: if (handshake)  next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        restart = 1'b0;
        if ((next_state == ST_CNU && state != ST_CNU) ||
            (next_state == ST_VNU && state != ST_VNU)) begin
            restart = 1'b1;
        end
    end

    ldpc_phase_timer #(
        .PHASE_CYC(PHASE_CYC)
    ) u_phase_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .done   (phase_done)
    );

    // Enables decode next_state so they coincide with the state register;
    // out_valid follows one cycle after DONE entry, after dec_out has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b1;
            llr_load  <= 1'b0;
            cnu_en    <= 1'b0;
            vnu_en    <= 1'b0;
            out_valid <= 1'b0;
            iter_cnt  <= '0;
            limit     <= '0;
            shift_cfg <= '0;
            dec_out   <= '0;
        end else begin
            ready     <= (next_state == ST_IDLE);
            llr_load  <= (next_state == ST_LOAD);
            cnu_en    <= (next_state == ST_CNU);
            vnu_en    <= (next_state == ST_VNU);
            out_valid <= (state == ST_DONE) && !handshake;
            if (accept) begin
                shift_cfg <= mtx_in;
                limit     <= (max_iter == '0) ? IT_W'(1) : max_iter;
                iter_cnt  <= '0;
            end
            if (vnu_exit) begin
                iter_cnt <= iter_nxt;
            end
            if (next_state == ST_DONE && state != ST_DONE) begin
                dec_out <= dec_in;
            end
        end
    end

`ifdef EARLY_TERM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            converged <= 1'b0;
        end else if (accept) begin
            converged <= 1'b0;
        end else if (state == ST_SYN && syn_ok) begin
            converged <= 1'b1;
        end else if (vnu_exit && last_iter) begin
            converged <= syn_ok;
        end
    end
`else
    logic unused_syn_ok;
    assign unused_syn_ok = syn_ok;
    assign converged     = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: table-driven frames with an expected-result queue, plus
// hand sequences for reset abort, early termination and PHASE_CYC=3.
module tb_ldpc_iter_ctrl;

    localparam int DW  = 4;
    localparam int RR  = 4;
    localparam int CC  = 2;
    localparam int DD  = 8;
    localparam int ITW = 5;
    localparam int MW  = DW * CC * RR;
    localparam int XW  = RR * DD;
`ifdef EARLY_TERM_EN
    localparam int SYN_EXTRA = 1;
`else
    localparam int SYN_EXTRA = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start, start3;
    logic [ITW-1:0] max_iter;
    logic [MW-1:0]  mtx_in;
    logic           syn_ok;
    logic [XW-1:0]  dec_in;
    logic           out_ready;

    logic           ready, llr_load, cnu_en, vnu_en, out_valid, converged;
    logic [MW-1:0]  shift_cfg;
    logic [XW-1:0]  dec_out;
    logic [ITW-1:0] iter_cnt;

    logic           ready3, llr_load3, cnu_en3, vnu_en3, out_valid3, converged3;
    logic [MW-1:0]  shift_cfg3;
    logic [XW-1:0]  dec_out3;
    logic [ITW-1:0] iter_cnt3;

    always #5 clk = ~clk;

    ldpc_iter_ctrl #(
        .data_w(DW), .R(RR), .C(CC), .D(DD), .IT_W(ITW), .PHASE_CYC(1)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .max_iter(max_iter), .mtx_in(mtx_in), .shift_cfg(shift_cfg),
        .llr_load(llr_load), .cnu_en(cnu_en), .vnu_en(vnu_en),
        .syn_ok(syn_ok), .dec_in(dec_in), .dec_out(dec_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .iter_cnt(iter_cnt), .converged(converged)
    );

    ldpc_iter_ctrl #(
        .data_w(DW), .R(RR), .C(CC), .D(DD), .IT_W(ITW), .PHASE_CYC(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .ready(ready3),
        .max_iter(max_iter), .mtx_in(mtx_in), .shift_cfg(shift_cfg3),
        .llr_load(llr_load3), .cnu_en(cnu_en3), .vnu_en(vnu_en3),
        .syn_ok(syn_ok), .dec_in(dec_in), .dec_out(dec_out3),
        .out_valid(out_valid3), .out_ready(out_ready),
        .iter_cnt(iter_cnt3), .converged(converged3)
    );

    typedef struct {
        logic [ITW-1:0] mi;
        logic [XW-1:0]  dval;
        int unsigned    hold;
        bit             toggle;
        bit             spam;
        bit             rdy_early;
        int unsigned    iter;
        int unsigned    lat;
    } vec_t;

    typedef struct {
        logic [XW-1:0] dec;
        int unsigned   iter;
        int unsigned   lat;
        logic [MW-1:0] mtx;
    } exp_t;

    vec_t        tbl [6];
    exp_t        sb [$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [XW-1:0] pattern(input int unsigned t);
        return XW'((t * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    endfunction

    task automatic run_frame(input vec_t v);
        exp_t          e;
        exp_t          g;
        int unsigned   t, n_llr, n_cnu, n_vnu, n_ovl, n_rdy, n_unst, lat_exp;
        logic [MW-1:0] m;
        m       = MW'($urandom);
        lat_exp = v.lat + SYN_EXTRA * (v.iter - 1);
        @(negedge clk);
        check("ready_before_start", ready, 1'b1);
        max_iter  = v.mi;
        mtx_in    = m;
        dec_in    = v.dval;
        out_ready = v.rdy_early;
        start     = 1'b1;
        e.dec  = v.toggle ? pattern(lat_exp - 2) : v.dval;
        e.iter = v.iter;
        e.lat  = lat_exp;
        e.mtx  = m;
        sb.push_back(e);
        @(negedge clk);
        start = v.spam;
        t = 0; n_llr = 0; n_cnu = 0; n_vnu = 0; n_ovl = 0; n_rdy = 0; n_unst = 0;
        while (!out_valid && t < 400) begin
            if (llr_load) n_llr++;
            if (cnu_en)   n_cnu++;
            if (vnu_en)   n_vnu++;
            if ((cnu_en && vnu_en) || (llr_load && (cnu_en || vnu_en))) n_ovl++;
            if (ready)    n_rdy++;
            mtx_in = MW'($urandom);
            if (v.toggle) dec_in = pattern(t);
            @(negedge clk);
            t++;
        end
        g = sb.pop_front();
        check("latency", t, g.lat);
        check("iter_cnt", iter_cnt, g.iter);
        check("dec_out", dec_out, g.dec);
        check("shift_cfg", shift_cfg, g.mtx);
        check("llr_pulses", n_llr, 1);
        check("cnu_cycles", n_cnu, g.iter);
        check("vnu_cycles", n_vnu, g.iter);
        check("enable_overlap", n_ovl, 0);
        check("ready_busy", n_rdy, 0);
        check("converged", converged, 1'b0);
        if (v.hold > 0) begin
            out_ready = 1'b0;
            for (int unsigned h = 0; h < v.hold; h++) begin
                if (v.toggle) dec_in = XW'($urandom);
                @(negedge clk);
                if (dec_out !== g.dec || out_valid !== 1'b1 || ready !== 1'b0) n_unst++;
            end
            check("hold_stable", n_unst, 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_hs_ready", ready, 1'b1);
        check("idle_after_hs_valid", out_valid, 1'b0);
        check("iter_cnt_kept", iter_cnt, g.iter);
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned t, n, cnu_runs, vnu_runs, run_c, run_v, n_ovl, n_after;
        bit          fired;

        //           mi     dval          hold toggle spam early iter lat
        tbl[0] = '{5'd4,  32'hDEADBEEF, 0,  1'b0, 1'b0, 1'b0, 4,  10};
        tbl[1] = '{5'd0,  32'h12345678, 0,  1'b0, 1'b0, 1'b0, 1,  4};
        tbl[2] = '{5'd1,  32'h0,        20, 1'b1, 1'b1, 1'b0, 1,  4};
        tbl[3] = '{5'd31, 32'hCAFEF00D, 0,  1'b0, 1'b0, 1'b1, 31, 64};
        tbl[4] = '{5'd3,  32'h0F0F00FF, 0,  1'b1, 1'b1, 1'b1, 3,  8};
        tbl[5] = '{5'd2,  32'hA5A5A5A5, 0,  1'b0, 1'b0, 1'b0, 2,  6};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; max_iter = '0; mtx_in = '0;
        syn_ok = 1'b0; dec_in = '0; out_ready = 1'b0;
        #12;
        check("rst_ready", ready, 1'b1);
        check("rst_llr", llr_load, 1'b0);
        check("rst_cnu", cnu_en, 1'b0);
        check("rst_vnu", vnu_en, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_iter", iter_cnt, 0);
        check("rst_shift", shift_cfg, 0);
        check("rst_dec", dec_out, 0);
        check("rst_conv", converged, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // Reset during the CNU phase of iteration 3
        @(negedge clk);
        max_iter = 5'd8; mtx_in = 32'h13572468; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!(iter_cnt == 5'd2 && cnu_en) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_iter3_cnu", (t < 100), 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_cnu", cnu_en, 1'b0);
        check("abort_vnu", vnu_en, 1'b0);
        check("abort_llr", llr_load, 1'b0);
        check("abort_iter", iter_cnt, 0);
        check("abort_shift", shift_cfg, 0);
        check("abort_dec", dec_out, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int unsigned k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid || !ready) n++;
        end
        check("abort_no_valid", n, 0);
        run_frame(tbl[0]);

`ifdef EARLY_TERM_EN
        @(negedge clk);
        max_iter = 5'd10; dec_in = 32'h600DD00D; syn_ok = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0; fired = 1'b0; n_after = 0;
        while (!out_valid && t < 200) begin
            if (fired && cnu_en) n_after++;
            syn_ok = (iter_cnt == 5'd2) && !cnu_en && !vnu_en && !llr_load;
            if (syn_ok) fired = 1'b1;
            @(negedge clk);
            t++;
        end
        syn_ok = 1'b0;
        check("et_latency", t, 8);
        check("et_iter", iter_cnt, 2);
        check("et_converged", converged, 1'b1);
        check("et_no_cnu_after", n_after, 0);
        check("et_dec", dec_out, 32'h600DD00D);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("et_idle", ready, 1'b1);
`endif

        // PHASE_CYC=3 instance, max_iter=2
        @(negedge clk);
        max_iter = 5'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        t = 0; cnu_runs = 0; vnu_runs = 0; run_c = 0; run_v = 0; n_ovl = 0;
        while (!out_valid3 && t < 200) begin
            if (cnu_en3) run_c++;
            else if (run_c != 0) begin check("p3_cnu_run", run_c, 3); cnu_runs++; run_c = 0; end
            if (vnu_en3) run_v++;
            else if (run_v != 0) begin check("p3_vnu_run", run_v, 3); vnu_runs++; run_v = 0; end
            if ((cnu_en3 && vnu_en3) || (llr_load3 && (cnu_en3 || vnu_en3))) n_ovl++;
            @(negedge clk);
            t++;
        end
        check("p3_latency", t, 14 + SYN_EXTRA);
        check("p3_cnu_runs", cnu_runs, 2);
        check("p3_vnu_runs", vnu_runs, 2);
        check("p3_overlap", n_ovl, 0);
        check("p3_iter", iter_cnt3, 2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("p3_idle", ready3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
